clock_rtc_alarm: RTL and testbench

//  Parametrised time-of-day counter with BCD sec/min/hour, prescaler and manual increments.

---
 rtl/clock_rtc_alarm_pkg.sv | 19 +
 rtl/clock_rtc_alarm_if.sv | 17 +
 rtl/clock_rtc_alarm_bcd_wrap_counter.sv | 20 ++
 rtl/clock_rtc_alarm.sv | 58 +++++
 tb/tb_clock_rtc_alarm.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/clock_rtc_alarm_pkg.sv
// clock_rtc_alarm_pkg: BCD limits and digit-wise helpers shared by the RTC blocks
package clock_rtc_alarm_pkg;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  function automatic logic [7:0] bcd_inc(input logic [7:0] x, input logic [7:0] max);
    return (x == max) ? 8'h00 : (x[3:0] == 4'h9) ? {x[7:4] + 4'h1, 4'h0} : {x[7:4], x[3:0] + 4'h1};
  endfunction
  function automatic logic bcd_ok(input logic [7:0] x, input logic [7:0] max);
    return (x[7:4] <= 4'h9) && (x[3:0] <= 4'h9) && (x <= max);
  endfunction
  // 13..23 go through binary so the tens digit borrows correctly
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    logic [4:0] r;
    r = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]) - 5'd12;
    return (h == 8'h00) ? BCD_12 : (h <= BCD_12) ? h :
           {3'b000, r >= 5'd10, (r >= 5'd10) ? r[3:0] - 4'd10 : r[3:0]};
  endfunction
endpackage

// File: rtl/clock_rtc_alarm_if.sv
// clock_rtc_alarm_if: control inputs and time/alarm outputs of the RTC
interface clock_rtc_alarm_if;
  logic       mode_12h, inc_sec, inc_min, inc_hour, load, alarm_en, alarm_ack;
  logic [7:0] load_hour, load_min, load_sec, alarm_hour, alarm_min;
  logic       tick_1Hz, end_of_day, pm, alarm, load_err;
  logic [7:0] sec, min, hour;
  modport master (
    output mode_12h, inc_sec, inc_min, inc_hour, load, alarm_en, alarm_ack,
           load_hour, load_min, load_sec, alarm_hour, alarm_min,
    input  tick_1Hz, end_of_day, pm, alarm, load_err, sec, min, hour
  );
  modport slave (
    input  mode_12h, inc_sec, inc_min, inc_hour, load, alarm_en, alarm_ack,
           load_hour, load_min, load_sec, alarm_hour, alarm_min,
    output tick_1Hz, end_of_day, pm, alarm, load_err, sec, min, hour
  );
endinterface

// File: rtl/clock_rtc_alarm_bcd_wrap_counter.sv
// clock_rtc_alarm_bcd_wrap_counter: two-digit BCD counter 00..MAX with clear, load and wrap flag
module clock_rtc_alarm_bcd_wrap_counter
  import clock_rtc_alarm_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_59
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o,
  output logic       wrap_o
);
  logic [7:0] q_q, q_d;
  always_comb q_d = clr_i ? 8'h00 : load_i ? d_i : inc_i ? bcd_inc(q_q, MAX) : q_q;
  always_ff @(posedge clk_i) q_q <= q_d;
  assign q_o    = q_q;
  assign wrap_o = inc_i && (q_q == MAX);
endmodule

// File: rtl/clock_rtc_alarm.sv
// clock_rtc_alarm: BCD time-of-day counter with prescaler, manual set, validated load,
// 12/24h display and hour:minute alarm
module clock_rtc_alarm
  import clock_rtc_alarm_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ
) (
  input logic              clk_100MHz,
  input logic              reset,
  clock_rtc_alarm_if.slave rtc
);
  localparam int PRESC_W = $clog2(TICK_DIV);
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic       tick_q, tick_d, eod_q, eod_d, alarm_q, alarm_d, err_q, err_d;
  logic [7:0] sec_q, min_q, hour_q;
  logic       load_ok, any_inc, wrap_now, tick_upd, alarm_hit;
  logic       sec_inc, min_inc, hour_inc, sec_wrap, min_wrap, hour_wrap;
  assign load_ok  = rtc.load && bcd_ok(rtc.load_hour, BCD_23) && bcd_ok(rtc.load_min, BCD_59)
                    && bcd_ok(rtc.load_sec, BCD_59);
  assign any_inc  = rtc.inc_sec || rtc.inc_min || rtc.inc_hour;
  assign wrap_now = presc_q == PRESC_W'(TICK_DIV - 1);
  // a tick moves the time only when no load or manual increment claims the cycle
  assign tick_upd = wrap_now && !load_ok && !any_inc;
  assign sec_inc  = rtc.inc_sec || tick_upd;
  assign min_inc  = rtc.inc_min || (tick_upd && sec_wrap);
  assign hour_inc = rtc.inc_hour || (tick_upd && sec_wrap && min_wrap);
  assign alarm_hit = tick_upd && sec_wrap && rtc.alarm_en
                     && bcd_inc(min_q, BCD_59) == rtc.alarm_min
                     && (min_wrap ? bcd_inc(hour_q, BCD_23) : hour_q) == rtc.alarm_hour;
  always_comb begin
    presc_d = (load_ok || wrap_now) ? '0 : presc_q + 1'b1;
    tick_d  = wrap_now && !load_ok;
    eod_d   = tick_upd && sec_wrap && min_wrap && hour_wrap;
    err_d   = rtc.load && !load_ok;
    alarm_d = (rtc.alarm_ack || !rtc.alarm_en) ? 1'b0 : alarm_q || alarm_hit;
  end
  always_ff @(posedge clk_100MHz)
    if (!reset) {presc_q, tick_q, eod_q, alarm_q, err_q} <= '0;
    else {presc_q, tick_q, eod_q, alarm_q, err_q} <= {presc_d, tick_d, eod_d, alarm_d, err_d};
  clock_rtc_alarm_bcd_wrap_counter #(.MAX(BCD_59)) u_sec (
    .clk_i(clk_100MHz), .clr_i(!reset), .inc_i(sec_inc), .load_i(load_ok),
    .d_i(rtc.load_sec), .q_o(sec_q), .wrap_o(sec_wrap));
  clock_rtc_alarm_bcd_wrap_counter #(.MAX(BCD_59)) u_min (
    .clk_i(clk_100MHz), .clr_i(!reset), .inc_i(min_inc), .load_i(load_ok),
    .d_i(rtc.load_min), .q_o(min_q), .wrap_o(min_wrap));
  clock_rtc_alarm_bcd_wrap_counter #(.MAX(BCD_23)) u_hour (
    .clk_i(clk_100MHz), .clr_i(!reset), .inc_i(hour_inc), .load_i(load_ok),
    .d_i(rtc.load_hour), .q_o(hour_q), .wrap_o(hour_wrap));
  assign rtc.tick_1Hz   = tick_q;
  assign rtc.end_of_day = eod_q;
  assign rtc.alarm      = alarm_q;
  assign rtc.load_err   = err_q;
  assign rtc.sec        = sec_q;
  assign rtc.min        = min_q;
  assign rtc.hour       = rtc.mode_12h ? to_12h(hour_q) : hour_q;
  assign rtc.pm         = hour_q >= BCD_12;
endmodule

// File: tb/tb_clock_rtc_alarm.sv
// tb_clock_rtc_alarm: seconds-of-day reference model checked every cycle, plus directed literal checks
module tb_clock_rtc_alarm;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic reset;
  bit   chk_on = 1'b0;
  int   tests = 0, fails = 0;
  clock_rtc_alarm_if rtc ();
  clock_rtc_alarm #(.CLK_FREQ_HZ(TD), .TICK_DIV(TD)) dut (.clk_100MHz(clk), .reset(reset), .rtc(rtc));
  always #5 clk = ~clk;

  int m_t, m_cnt, mh, mm, ms;
  bit m_tick, m_eod, m_alarm, m_err, m_ok;
  function automatic bit bok(logic [7:0] x, int mx);
    return x[7:4] <= 4'd9 && x[3:0] <= 4'd9 && (int'(x[7:4]) * 10 + int'(x[3:0])) <= mx;
  endfunction
  function automatic int bv(logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction
  function automatic logic [7:0] tb_bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_t = 0; m_cnt = 0; m_tick = 0; m_eod = 0; m_alarm = 0; m_err = 0;
    end else begin
      m_ok = bok(rtc.load_hour, 23) && bok(rtc.load_min, 59) && bok(rtc.load_sec, 59);
      if (rtc.load && m_ok) begin
        m_t = bv(rtc.load_hour) * 3600 + bv(rtc.load_min) * 60 + bv(rtc.load_sec);
        m_cnt = 0; m_tick = 0; m_eod = 0; m_err = 0;
      end else begin
        m_err = rtc.load; m_eod = 0;
        m_tick = (m_cnt == TD - 1);
        m_cnt = (m_cnt + 1) % TD;
        if (rtc.inc_sec || rtc.inc_min || rtc.inc_hour) begin
          mh = m_t / 3600; mm = (m_t / 60) % 60; ms = m_t % 60;
          if (rtc.inc_sec) ms = (ms + 1) % 60;
          if (rtc.inc_min) mm = (mm + 1) % 60;
          if (rtc.inc_hour) mh = (mh + 1) % 24;
          m_t = mh * 3600 + mm * 60 + ms;
        end else if (m_tick) begin
          m_eod = (m_t == 86399);
          m_t = (m_t + 1) % 86400;
          if (rtc.alarm_en && m_t == bv(rtc.alarm_hour) * 3600 + bv(rtc.alarm_min) * 60) m_alarm = 1;
        end
      end
      if (rtc.alarm_ack || !rtc.alarm_en) m_alarm = 0;
    end
  end

  int ch, chd;
  logic [28:0] exp_v, act_v;
  always @(negedge clk) if (chk_on) begin
    ch = m_t / 3600;
    chd = rtc.mode_12h ? ((ch % 12 == 0) ? 12 : ch % 12) : ch;
    exp_v = {m_tick, m_eod, tb_bcd(m_t % 60), tb_bcd((m_t / 60) % 60), tb_bcd(chd), ch >= 12, m_alarm, m_err};
    act_v = {rtc.tick_1Hz, rtc.end_of_day, rtc.sec, rtc.min, rtc.hour, rtc.pm, rtc.alarm, rtc.load_err};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL model_cmp t=%0t act{tick,eod,sec,min,hour,pm,alarm,err}=%h exp=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(string n, logic [7:0] a, logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_load(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    rtc.load = 1; rtc.load_hour = h; rtc.load_min = m; rtc.load_sec = s;
    cyc(1);
    rtc.load = 0;
  endtask

  initial begin
    reset = 0;
    {rtc.mode_12h, rtc.inc_sec, rtc.inc_min, rtc.inc_hour, rtc.load, rtc.alarm_en, rtc.alarm_ack} = '0;
    {rtc.load_hour, rtc.load_min, rtc.load_sec, rtc.alarm_hour, rtc.alarm_min} = '0;
    cyc(1);
    chk_on = 1;
    cyc(9);
    chk("rst_sec", rtc.sec, 8'h00);
    chk("rst_hour", rtc.hour, 8'h00);
    chk("rst_tick", 8'(rtc.tick_1Hz), 8'h00);
    rtc.mode_12h = 1; #1;
    chk("rst_hour12", rtc.hour, 8'h12);
    chk("rst_pm", 8'(rtc.pm), 8'h00);
    rtc.mode_12h = 0;
    reset = 1;
    cyc(12);
    chk("tick3_sec", rtc.sec, 8'h03);
    chk("tick3_min", rtc.min, 8'h00);
    chk("tick3_tick", 8'(rtc.tick_1Hz), 8'h01);
    cyc(2);
    reset = 0; cyc(1); reset = 1;
    cyc(3);
    chk("midrst_notick", 8'(rtc.tick_1Hz), 8'h00);
    cyc(1);
    chk("midrst_tick", 8'(rtc.tick_1Hz), 8'h01);
    chk("midrst_sec", rtc.sec, 8'h01);
    do_load(8'h23, 8'h59, 8'h58);
    chk("eod_pm1", 8'(rtc.pm), 8'h01);
    cyc(4);
    chk("eod_sec59", rtc.sec, 8'h59);
    cyc(4);
    chk("eod_pulse", 8'(rtc.end_of_day), 8'h01);
    chk("eod_hour", rtc.hour, 8'h00);
    chk("eod_pm0", 8'(rtc.pm), 8'h00);
    cyc(1);
    chk("eod_once", 8'(rtc.end_of_day), 8'h00);
    do_load(8'h12, 8'h00, 8'h1A);
    chk("bad_sec_err", 8'(rtc.load_err), 8'h01);
    chk("bad_sec_hour", rtc.hour, 8'h00);
    chk("bad_sec_sec", rtc.sec, 8'h00);
    cyc(1);
    chk("err_pulse", 8'(rtc.load_err), 8'h00);
    do_load(8'h24, 8'h00, 8'h00);
    chk("bad_hour_err", 8'(rtc.load_err), 8'h01);
    chk("bad_hour_hour", rtc.hour, 8'h00);
    do_load(8'h05, 8'h60, 8'h00);
    chk("bad_min_err", 8'(rtc.load_err), 8'h01);
    rtc.mode_12h = 1;
    do_load(8'h00, 8'h00, 8'h00);
    chk("h12_mid", rtc.hour, 8'h12);
    chk("h12_mid_pm", 8'(rtc.pm), 8'h00);
    do_load(8'h13, 8'h05, 8'h00);
    chk("h12_13", rtc.hour, 8'h01);
    chk("h12_13_pm", 8'(rtc.pm), 8'h01);
    do_load(8'h20, 8'h00, 8'h00);
    chk("h12_20", rtc.hour, 8'h08);
    do_load(8'h12, 8'h00, 8'h00);
    chk("h12_noon", rtc.hour, 8'h12);
    rtc.mode_12h = 0; #1;
    chk("h24_noon", rtc.hour, 8'h12);
    do_load(8'h10, 8'h59, 8'h30);
    rtc.inc_min = 1; cyc(1); rtc.inc_min = 0;
    chk("incmin_min", rtc.min, 8'h00);
    chk("incmin_hour", rtc.hour, 8'h10);
    chk("incmin_sec", rtc.sec, 8'h30);
    cyc(2);
    rtc.inc_sec = 1; cyc(1); rtc.inc_sec = 0;
    chk("incsec_tick", 8'(rtc.tick_1Hz), 8'h01);
    chk("incsec_sec", rtc.sec, 8'h31);
    do_load(8'h23, 8'h59, 8'h59);
    {rtc.inc_sec, rtc.inc_min, rtc.inc_hour} = 3'b111; cyc(1); {rtc.inc_sec, rtc.inc_min, rtc.inc_hour} = 3'b000;
    chk("incall_hour", rtc.hour, 8'h00);
    chk("incall_sec", rtc.sec, 8'h00);
    chk("incall_noeod", 8'(rtc.end_of_day), 8'h00);
    rtc.alarm_en = 1; rtc.alarm_hour = 8'h07; rtc.alarm_min = 8'h30;
    do_load(8'h07, 8'h29, 8'h59);
    cyc(4);
    chk("alarm_set", 8'(rtc.alarm), 8'h01);
    cyc(3);
    chk("alarm_hold", 8'(rtc.alarm), 8'h01);
    rtc.alarm_ack = 1; cyc(1); rtc.alarm_ack = 0;
    chk("alarm_ack", 8'(rtc.alarm), 8'h00);
    do_load(8'h07, 8'h29, 8'h59);
    cyc(3);
    rtc.alarm_ack = 1; cyc(1); rtc.alarm_ack = 0;
    chk("alarm_clr_wins", 8'(rtc.alarm), 8'h00);
    rtc.alarm_en = 0;
    do_load(8'h07, 8'h29, 8'h59);
    cyc(4);
    chk("alarm_disabled", 8'(rtc.alarm), 8'h00);
    rtc.alarm_en = 1;
    do_load(8'h07, 8'h29, 8'h59);
    cyc(4);
    chk("alarm_set2", 8'(rtc.alarm), 8'h01);
    rtc.alarm_en = 0; cyc(1);
    chk("alarm_en_clr", 8'(rtc.alarm), 8'h00);
    cyc(2);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
